// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner: per-digit hex/raw decode, PWM brightness
// with a dead time at each slot start, and frame-aligned shadow -> active update.
module sevenseg_scan #(
    parameter int CLK_HZ      = 100000000,
    parameter int RATE_HZ     = 1000,
    parameter int DIGITS      = 3,
    parameter int BR_W        = 3,
    parameter int DEAD_CYC    = 2,
    parameter int SEG_ACT_LOW = 1,
    parameter int EN_ACT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [8*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     hex_mask,
    input  logic [BR_W-1:0]       bright,
    input  logic                  enable,
    output logic [7:0]            ss,
    output logic [DIGITS-1:0]     ssen,
    output logic                  frame_start
);

    localparam int PERIOD = CLK_HZ / (RATE_HZ * DIGITS);
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // EW holds any value 0..PERIOD, enough for slot positions and window ends
    localparam int EW     = $clog2(PERIOD + 1);
    localparam int PRW    = BR_W + 1 + EW;

    if (PERIOD <= DEAD_CYC) begin : g_period_chk
        $error("sevenseg_scan: slot period must exceed DEAD_CYC");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_digits_chk
        $error("sevenseg_scan: DIGITS must be 1..8");
    end

    logic [CW-1:0]              slot_cnt, slot_nxt;
    logic [DW-1:0]              dig_idx, dig_nxt;
    logic                       slot_wrap, frame_wrap;
    logic [DIGITS-1:0][7:0]     shd_data, act_data, act_data_nxt;
    logic [DIGITS-1:0]          shd_mask, act_mask, act_mask_nxt;
    logic [7:0]                 seg_q, seg_nxt;
    logic [EW-1:0]              on_q, on_nxt, on_bright, slot_e, win_hi;
    logic [PRW-1:0]             on_prod;
    logic                       en_q, en_nxt;
    logic [DIGITS-1:0]          en_vec;

    function automatic logic [7:0] decode(input logic [7:0] b, input logic hex);
        logic [6:0] s;
        case (b[3:0])
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return hex ? {b[7], s} : b;
    endfunction

    // Next-state of the scan plus everything presented in the coming cycle;
    // outputs are registered from next-state so segments, enable window and
    // frame_start all line up with slot_cnt/dig_idx.
    always_comb begin
        slot_wrap    = (slot_cnt == CW'(PERIOD - 1));
        frame_wrap   = slot_wrap && (dig_idx == DW'(DIGITS - 1));
        slot_nxt     = slot_wrap ? '0 : slot_cnt + CW'(1);
        dig_nxt      = dig_idx;
        if (frame_wrap)     dig_nxt = '0;
        else if (slot_wrap) dig_nxt = dig_idx + DW'(1);
        // pre-edge shadow: a load landing on the wrap edge waits one frame
        act_data_nxt = frame_wrap ? shd_data : act_data;
        act_mask_nxt = frame_wrap ? shd_mask : act_mask;
        seg_nxt      = seg_q;
        if (slot_nxt == '0)
            seg_nxt = decode(act_data_nxt[dig_nxt], act_mask_nxt[dig_nxt]);
        // full-precision on-time; result never exceeds PERIOD-DEAD_CYC
        on_prod      = (PRW'(bright) + PRW'(1)) * PRW'(PERIOD - DEAD_CYC);
        on_bright    = EW'(on_prod >> BR_W);
        on_nxt       = (slot_nxt == '0) ? on_bright : on_q;
        slot_e       = EW'(slot_nxt);
        win_hi       = EW'(DEAD_CYC) + on_nxt;
        en_nxt       = enable && (slot_e >= EW'(DEAD_CYC)) && (slot_e < win_hi);
    end

    // Scan counters, shadow/active data and registered output state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt    <= '0;
            dig_idx     <= '0;
            shd_data    <= '0;
            shd_mask    <= '0;
            act_data    <= '0;
            act_mask    <= '0;
            seg_q       <= '0;
            on_q        <= '0;
            en_q        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            slot_cnt    <= slot_nxt;
            dig_idx     <= dig_nxt;
            if (load) begin
                shd_data <= data;
                shd_mask <= hex_mask;
            end
            act_data    <= act_data_nxt;
            act_mask    <= act_mask_nxt;
            seg_q       <= seg_nxt;
            on_q        <= on_nxt;
            en_q        <= en_nxt;
            frame_start <= (slot_nxt == '0) && (dig_nxt == '0);
        end
    end

    // Only the scanned digit may ever be enabled, so the vector is one-hot or zero
    for (genvar i = 0; i < DIGITS; i++) begin : g_en
        assign en_vec[i] = en_q && (dig_idx == DW'(i));
    end

    assign ss   = (SEG_ACT_LOW != 0) ? ~seg_q  : seg_q;
    assign ssen = (EN_ACT_LOW  != 0) ? ~en_vec : en_vec;

endmodule
